// File: rtl/systolic_feeder.sv
// Feeder stage for systolic_array: buffers A and B, clears the accumulators row by row,
// then streams both matrices in with diagonal skew so PE(i,j) accumulates sum_k A[i][k]*B[k][j].
module systolic_feeder #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [$clog2(DIM)-1:0]           load_row,
    input  logic [DIM-1:0][BITS_AB-1:0]      load_A,
    input  logic [DIM-1:0][BITS_AB-1:0]      load_B,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [DIM-1:0][BITS_AB-1:0]      A_out,
    output logic [DIM-1:0][BITS_AB-1:0]      B_out,
    output logic [DIM-1:0][BITS_C-1:0]       Cin,
    output logic [$clog2(DIM)-1:0]           Crow,
    output logic                             WrEn,
    output logic                             en
);

    localparam int IW = $clog2(DIM);
    localparam int CW = $clog2(3 * DIM);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(DIM - 1);
    localparam logic [CW-1:0] FEED_LAST  = CW'(3 * DIM - 3);

    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DONE} state_t;

    state_t                                 state;
    logic [CW-1:0]                          cnt;
    logic [CW-1:0]                          t_next;
    logic [CW:0]                            k_idx [DIM];
    logic [DIM-1:0][DIM-1:0][BITS_AB-1:0]   buf_a;
    logic [DIM-1:0][DIM-1:0][BITS_AB-1:0]   buf_b;
    logic [DIM-1:0][BITS_AB-1:0]            feed_a;
    logic [DIM-1:0][BITS_AB-1:0]            feed_b;

    assign Cin = '0;

    // load_ready is only high in IDLE, so a write on the start edge still lands before FEED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_a <= '0;
            buf_b <= '0;
        end else if (load_valid && load_ready) begin
            buf_a[load_row] <= load_A;
            buf_b[load_row] <= load_B;
        end
    end

    // Skew lane for the value of t that will be presented after the next edge. The
    // subtraction is one bit wider so t<i wraps to a huge value and fails the range check.
    always_comb begin
        t_next = (state == FEED) ? cnt + CW'(1) : '0;
        for (int i = 0; i < DIM; i++) begin
            k_idx[i]  = {1'b0, t_next} - (CW + 1)'(i);
            feed_a[i] = '0;
            feed_b[i] = '0;
            if (k_idx[i] < (CW + 1)'(DIM)) begin
                feed_a[i] = buf_a[i][k_idx[i][IW-1:0]];
                feed_b[i] = buf_b[k_idx[i][IW-1:0]][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            load_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            WrEn       <= 1'b0;
            en         <= 1'b0;
            Crow       <= '0;
            A_out      <= '0;
            B_out      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                        WrEn       <= 1'b1;
                        Crow       <= '0;
                    end else begin
                        load_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == CLEAR_LAST) begin
                        state <= FEED;
                        cnt   <= '0;
                        WrEn  <= 1'b0;
                        Crow  <= '0;
                        en    <= 1'b1;
                        A_out <= feed_a;
                        B_out <= feed_b;
                    end else begin
                        cnt  <= cnt + CW'(1);
                        Crow <= IW'(cnt + CW'(1));
                    end
                end
                FEED: begin
                    if (cnt == FEED_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        A_out <= '0;
                        B_out <= '0;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        A_out <= feed_a;
                        B_out <= feed_b;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: per-cycle scoreboard of the clear/feed timeline
// built from a reference copy of the matrices, plus a table of skew sample points.
module tb_systolic_feeder;

    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 8;
    localparam int IW      = 3;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b0;
    logic                         load_valid = 1'b0;
    logic                         start = 1'b0;
    logic [IW-1:0]                load_row = '0;
    logic [DIM-1:0][BITS_AB-1:0]  load_A = '0;
    logic [DIM-1:0][BITS_AB-1:0]  load_B = '0;
    logic                         load_ready, busy, done, WrEn, en;
    logic [IW-1:0]                Crow;
    logic [DIM-1:0][BITS_AB-1:0]  A_out, B_out;
    logic [DIM-1:0][BITS_C-1:0]   Cin;

    systolic_feeder #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready), .load_row(load_row),
        .load_A(load_A), .load_B(load_B), .start(start),
        .busy(busy), .done(done), .A_out(A_out), .B_out(B_out),
        .Cin(Cin), .Crow(Crow), .WrEn(WrEn), .en(en)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic                         ready;
        logic                         busy;
        logic                         done;
        logic                         wren;
        logic                         en;
        logic [IW-1:0]                crow;
        logic [DIM-1:0][BITS_AB-1:0]  a;
        logic [DIM-1:0][BITS_AB-1:0]  b;
    } exp_t;

    typedef struct {
        int                 t;
        int                 lane;
        logic [BITS_AB-1:0] exp_a;
    } skew_vec_t;

    logic [BITS_AB-1:0]           mod_a [DIM][DIM];
    logic [BITS_AB-1:0]           mod_b [DIM][DIM];
    logic [DIM-1:0][BITS_AB-1:0]  cap_a [3*DIM-2];
    exp_t                         sb_q[$];
    int                           errors = 0;
    int                           checks = 0;
    int                           done_n;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic exp_t expectFor(int n);
        exp_t e;
        int   t;
        e = '0;
        if (n >= 1 && n <= DIM) begin
            e.busy = 1'b1;
            e.wren = 1'b1;
            e.crow = IW'(n - 1);
        end else if (n >= DIM + 1 && n <= 4*DIM - 2) begin
            t = n - DIM - 1;
            e.busy = 1'b1;
            e.en   = 1'b1;
            for (int i = 0; i < DIM; i++) begin
                if (t - i >= 0 && t - i < DIM) begin
                    e.a[i] = mod_a[i][t-i];
                    e.b[i] = mod_b[t-i][i];
                end
            end
        end else if (n == 4*DIM - 1) begin
            e.done = 1'b1;
        end else begin
            e.ready = 1'b1;
        end
        return e;
    endfunction

    task automatic setModelRow(input int r, input logic [DIM-1:0][BITS_AB-1:0] a,
                               input logic [DIM-1:0][BITS_AB-1:0] b);
        for (int k = 0; k < DIM; k++) begin
            mod_a[r][k] = a[k];
            mod_b[r][k] = b[k];
        end
    endtask

    task automatic loadRow(input int r, input logic [DIM-1:0][BITS_AB-1:0] a,
                           input logic [DIM-1:0][BITS_AB-1:0] b);
        @(negedge clk);
        load_valid = 1'b1;
        load_row   = IW'(r);
        load_A     = a;
        load_B     = b;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        setModelRow(r, a, b);
    endtask

    task automatic compareCycle(input int n);
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput("scoreboard_empty", 128'd1, 128'd0);
            return;
        end
        e = sb_q.pop_front();
        checkOutput($sformatf("ctrl@%0d", n), {load_ready, busy, done, WrEn, en, Crow},
                    {e.ready, e.busy, e.done, e.wren, e.en, e.crow});
        checkOutput($sformatf("A_out@%0d", n), A_out, e.a);
        checkOutput($sformatf("B_out@%0d", n), B_out, e.b);
        checkOutput($sformatf("Cin@%0d", n), Cin, '0);
        if (e.en) cap_a[n-DIM-1] = A_out;
        if (done && done_n < 0) done_n = n;
    endtask

    // One full start-to-idle run; optionally loads a row on the start edge and pokes
    // start/load_valid while busy (those must have no effect).
    task automatic applyStimulus(input bit with_load, input int row,
                                 input logic [DIM-1:0][BITS_AB-1:0] a,
                                 input logic [DIM-1:0][BITS_AB-1:0] b, input bit noise);
        @(negedge clk);
        start = 1'b1;
        if (with_load) begin
            load_valid = 1'b1;
            load_row   = IW'(row);
            load_A     = a;
            load_B     = b;
            setModelRow(row, a, b);
        end
        for (int n = 1; n <= 4*DIM; n++) sb_q.push_back(expectFor(n));
        done_n = -1;
        for (int n = 1; n <= 4*DIM; n++) begin
            @(posedge clk);
            #1;
            start      = 1'b0;
            load_valid = 1'b0;
            if (noise && (n == 3 || n == DIM + 4)) begin
                start      = 1'b1;
                load_valid = 1'b1;
                load_row   = '0;
                load_A     = {DIM{8'h5A}};
                load_B     = {DIM{8'hA5}};
            end
            @(negedge clk);
            compareCycle(n);
        end
        checkOutput("done_cycle", 128'(done_n), 128'(4*DIM - 1));
    endtask

    initial begin
        skew_vec_t                   skew_tab [8];
        logic [DIM-1:0][BITS_AB-1:0] ra, rb;

        skew_tab[0] = '{t: 5,  lane: 2, exp_a: 8'h23};
        skew_tab[1] = '{t: 5,  lane: 6, exp_a: 8'h00};
        skew_tab[2] = '{t: 5,  lane: 0, exp_a: 8'h05};
        skew_tab[3] = '{t: 0,  lane: 0, exp_a: 8'h00};
        skew_tab[4] = '{t: 7,  lane: 7, exp_a: 8'h70};
        skew_tab[5] = '{t: 14, lane: 7, exp_a: 8'h77};
        skew_tab[6] = '{t: 15, lane: 7, exp_a: 8'h00};
        skew_tab[7] = '{t: 8,  lane: 0, exp_a: 8'h00};

        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                mod_a[r][k] = '0;
                mod_b[r][k] = '0;
            end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {load_ready, busy, done, WrEn, en, Crow}, '0);
        checkOutput("reset_A_out", A_out, '0);
        checkOutput("reset_B_out", B_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_ctrl", {load_ready, busy, done, WrEn, en, Crow}, 8'b1000_0000);

        $display("[TB] identity A, ramp B");
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) begin
                ra[k] = (r == k) ? 8'd1 : 8'd0;
                rb[k] = 8'(r * 8 + k);
            end
            loadRow(r, ra, rb);
        end
        applyStimulus(1'b0, 0, '0, '0, 1'b0);

        $display("[TB] skew pattern A[i][k]=16i+k");
        for (int r = 0; r < DIM; r++) begin
            for (int k = 0; k < DIM; k++) begin
                ra[k] = 8'(16 * r + k);
                rb[k] = 8'($urandom_range(0, 255));
            end
            loadRow(r, ra, rb);
        end
        applyStimulus(1'b0, 0, '0, '0, 1'b0);
        for (int v = 0; v < 8; v++)
            checkOutput($sformatf("skew_t%0d_lane%0d", skew_tab[v].t, skew_tab[v].lane),
                        cap_a[skew_tab[v].t][skew_tab[v].lane], skew_tab[v].exp_a);

        $display("[TB] start/load while busy, then re-stream");
        applyStimulus(1'b0, 0, '0, '0, 1'b1);

        $display("[TB] load and start in the same cycle");
        applyStimulus(1'b1, 2, {DIM{8'h7F}}, {DIM{8'h01}}, 1'b0);

        $display("[TB] signed extremes");
        for (int r = 0; r < DIM; r++) loadRow(r, {DIM{8'h80}}, {DIM{8'h80}});
        applyStimulus(1'b0, 0, '0, '0, 1'b0);

        $display("[TB] reset mid-feed");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (DIM + 5) @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_en", en, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_ctrl", {load_ready, busy, done, WrEn, en, Crow}, '0);
        checkOutput("midreset_A_out", A_out, '0);
        checkOutput("midreset_B_out", B_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < DIM; r++)
            for (int k = 0; k < DIM; k++) begin
                mod_a[r][k] = '0;
                mod_b[r][k] = '0;
            end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_ready", load_ready, 1'b1);
        applyStimulus(1'b0, 0, '0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
